// File: rtl/seq_det_param_if.sv
// seq_det_param_if: stream, configuration and status signals of the
// parametrised serial sequence detector. The master drives the bit stream and
// the configuration; the slave (the detector) returns match, count and fill.
interface seq_det_param_if #(
    parameter int PAT_W = 8,
    parameter int LEN_W = 4,
    parameter int CNT_W = 8
);
    logic             in_valid;
    logic             in;
    logic             cfg_load;
    logic [PAT_W-1:0] cfg_pattern;
    logic [LEN_W-1:0] cfg_len;
    logic             cfg_overlap;
    logic             cnt_clr;
    logic             out;
    logic [CNT_W-1:0] match_cnt;
    logic [LEN_W-1:0] fill;

    modport master (
        output in_valid, in, cfg_load, cfg_pattern, cfg_len, cfg_overlap, cnt_clr,
        input  out, match_cnt, fill
    );

    modport slave (
        input  in_valid, in, cfg_load, cfg_pattern, cfg_len, cfg_overlap, cnt_clr,
        output out, match_cnt, fill
    );
endinterface

// File: rtl/seq_det_param.sv
// seq_det_param: runtime-configurable Mealy serial sequence detector for
// sync-word / framing detection. The pattern (LSB = last bit received), its
// length (1..PAT_W, 0 disables) and overlap mode are loaded through cfg_load.
// A combinational match pulse is produced in the cycle the final pattern bit
// is presented, and matches are tallied in a saturating counter.
// Optional build macro SEQ_DET_STICKY_EN: adds a sticky "seen a match" flag
// that is ORed into the MSB of match_cnt on the port.
module seq_det_param #(
    parameter int               PAT_W   = 8,
    parameter int               LEN_W   = 4,
    parameter int               CNT_W   = 8,
    parameter logic [PAT_W-1:0] DEF_PAT = PAT_W'(8'b0000_1011),
    parameter logic [LEN_W-1:0] DEF_LEN = LEN_W'(4),
    parameter logic             DEF_OVL = 1'b1
) (
    input logic               clk,
    input logic               rst,
    seq_det_param_if.slave    bus
);

    logic [PAT_W-2:0] r_hist;
    logic [PAT_W-1:0] r_pat;
    logic [LEN_W-1:0] r_len;
    logic             r_ovl;
    logic [LEN_W-1:0] r_fill;
    logic [CNT_W-1:0] r_cnt;

    logic [PAT_W-1:0] w_window;
    logic [PAT_W-1:0] w_mask;
    logic [LEN_W-1:0] w_len_clamped;
    logic [LEN_W-1:0] w_fill_inc;
    logic             w_qual;
    logic             w_fill_ok;
    logic             w_match;
    logic             w_out;

    // Compare mask: the low r_len bits of the window take part in the match.
    always_comb begin
        // NOTE: give every always_comb output a value before any condition so no latch is inferred.
        w_mask = '0;
        for (int i = 0; i < PAT_W; i++) begin
            if (i < int'(r_len)) w_mask[i] = 1'b1;
        end
    end

    assign w_window      = {r_hist, bus.in};
    assign w_qual        = bus.in_valid & ~bus.cfg_load;
    assign w_fill_ok     = (r_len != '0) && (r_fill >= r_len - LEN_W'(1));
    assign w_match       = ((w_window ^ r_pat) & w_mask) == '0;
    assign w_out         = w_qual & w_fill_ok & w_match;
    assign w_len_clamped = (bus.cfg_len > LEN_W'(PAT_W)) ? LEN_W'(PAT_W) : bus.cfg_len;
    // fill saturates one short of PAT_W: that is already enough history for any length.
    assign w_fill_inc    = (r_fill == LEN_W'(PAT_W - 1)) ? r_fill : r_fill + LEN_W'(1);

    // Configuration registers: latched on cfg_load, lengths above PAT_W clamped.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!rst) begin
            r_pat <= DEF_PAT;
            r_len <= DEF_LEN;
            r_ovl <= DEF_OVL;
        end else if (bus.cfg_load) begin
            r_pat <= bus.cfg_pattern;
            r_len <= w_len_clamped;
            r_ovl <= bus.cfg_overlap;
        end
    end

    // Bit history and fill level; a load restarts detection, a non-overlapping match restarts fill.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_hist <= '0;
            r_fill <= '0;
        end else if (bus.cfg_load) begin
            r_hist <= '0;
            r_fill <= '0;
        end else if (bus.in_valid) begin
            r_hist <= w_window[PAT_W-2:0];
            r_fill <= (w_out && !r_ovl) ? '0 : w_fill_inc;
        end
    end

    // Saturating match counter; a clear beats a simultaneous match.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (bus.cnt_clr) begin
            r_cnt <= '0;
        end else if (w_out && (r_cnt != '1)) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

`ifdef SEQ_DET_STICKY_EN
    localparam logic [CNT_W-1:0] CNT_MSB = CNT_W'(1) << (CNT_W - 1);

    logic r_sticky;

    // Sticky flag: remembers any match until the counter is cleared.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sticky <= 1'b0;
        end else if (bus.cnt_clr) begin
            r_sticky <= 1'b0;
        end else if (w_out) begin
            r_sticky <= 1'b1;
        end
    end

    assign bus.match_cnt = r_cnt | (r_sticky ? CNT_MSB : '0);
`else
    assign bus.match_cnt = r_cnt;
`endif

    assign bus.out  = w_out;
    assign bus.fill = r_fill;

endmodule
